// File: rtl/gnr_pkg.sv
// gnr_pkg: shared FSM state encoding, result record and default sizes for the attractor controller.
package gnr_pkg;
   localparam int GNR_N_NODES = 4;
   localparam int GNR_CNT_W = 16;
   typedef enum logic [2:0] {IDLE, LOAD, RUN, PERIOD, REPORT} gnr_state_e;
   typedef struct packed {
      logic [GNR_N_NODES-1:0] init;
      logic [GNR_CNT_W-1:0]   steps;
      logic [GNR_CNT_W-1:0]   period;
      logic                   timeout;
   } gnr_res_t;
endpackage

// File: rtl/gnr_step_cnt.sv
// gnr_step_cnt: saturating up-counter with a programmable clear value and a limit flag.
module gnr_step_cnt #(
   parameter int W = 16,
   parameter int LIMIT = 2**16 - 1,
   parameter int CLR_VAL = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         at_max
);
   localparam logic [W-1:0] LIM = W'(LIMIT);
   localparam logic [W-1:0] CV = W'(CLR_VAL);
   assign at_max = cnt == LIM;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else if (clr) cnt <= CV;
      else if (en && !at_max) cnt <= cnt + W'(1);
   end
endmodule

// File: rtl/gnr_attractor_ctrl.sv
// gnr_attractor_ctrl: Floyd tortoise/hare attractor search over an external node array.
// Define GNR_CTRL_PERIOD_EN to build the PERIOD state and measure the attractor period.
module gnr_attractor_ctrl
   import gnr_pkg::*;
#(
   parameter int N_NODES = GNR_N_NODES,
   parameter int CNT_W = GNR_CNT_W,
   parameter int MAX_STEPS = 2**CNT_W - 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               abort,
   input  logic               init_valid,
   output logic               init_ready,
   input  logic [N_NODES-1:0] init_data,
   input  logic               init_last,
   input  logic [N_NODES-1:0] s0_vec,
   input  logic [N_NODES-1:0] s1_vec,
   output logic               reset_nos,
   output logic               start_s0,
   output logic               start_s1,
   output logic [N_NODES-1:0] init_state,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [N_NODES-1:0] res_init,
   output logic [CNT_W-1:0]   res_steps,
   output logic [CNT_W-1:0]   res_period,
   output logic               res_timeout,
   output logic               done
);
   gnr_state_e state;
   logic last_q, accept, meet, step_max;
   logic [CNT_W-1:0] step_cnt;
   assign accept = state == IDLE && init_valid && init_ready;
   // the hare has taken step_cnt steps and the tortoise half as many; compare only on even counts
   assign meet = state == RUN && !step_cnt[0] && step_cnt != '0 && s0_vec == s1_vec;
   gnr_step_cnt #(.W(CNT_W), .LIMIT(MAX_STEPS), .CLR_VAL(0)) u_step_cnt (
      .clk(clk), .rst(rst), .clr(state != RUN), .en(state == RUN), .cnt(step_cnt), .at_max(step_max)
   );
`ifdef GNR_CTRL_PERIOD_EN
   logic per_hit, per_max;
   logic [CNT_W-1:0] per_cnt;
   assign per_hit = state == PERIOD && s1_vec == s0_vec;
   gnr_step_cnt #(.W(CNT_W), .LIMIT(MAX_STEPS), .CLR_VAL(1)) u_per_cnt (
      .clk(clk), .rst(rst), .clr(state != PERIOD), .en(state == PERIOD), .cnt(per_cnt), .at_max(per_max)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) res_period <= '0;
      else if (accept) res_period <= '0;
      else if (per_hit && !abort) res_period <= per_cnt;
   end
`else
   assign res_period = '0;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         last_q <= 1'b0;
         init_ready <= 1'b0;
         reset_nos <= 1'b0;
         start_s0 <= 1'b0;
         start_s1 <= 1'b0;
         init_state <= '0;
         res_valid <= 1'b0;
         res_init <= '0;
         res_steps <= '0;
         res_timeout <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort && state != IDLE) begin
            state <= IDLE;
            init_ready <= 1'b1;
            reset_nos <= 1'b0;
            start_s0 <= 1'b0;
            start_s1 <= 1'b0;
            res_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  init_ready <= ~accept;
                  if (accept) begin
                     state <= LOAD;
                     last_q <= init_last;
                     init_state <= init_data;
                     res_init <= init_data;
                     res_steps <= '0;
                     res_timeout <= 1'b0;
                     reset_nos <= 1'b1;
                  end
               end
               LOAD: begin
                  state <= RUN;
                  reset_nos <= 1'b0;
                  start_s0 <= 1'b1;
                  start_s1 <= 1'b1;
               end
               RUN: begin
                  if (meet) begin
                     res_steps <= step_cnt;
                     start_s0 <= 1'b0;
`ifdef GNR_CTRL_PERIOD_EN
                     state <= PERIOD;
`else
                     state <= REPORT;
                     start_s1 <= 1'b0;
                     res_valid <= 1'b1;
`endif
                  end else if (step_max) begin
                     state <= REPORT;
                     res_timeout <= 1'b1;
                     start_s0 <= 1'b0;
                     start_s1 <= 1'b0;
                     res_valid <= 1'b1;
                  end
               end
`ifdef GNR_CTRL_PERIOD_EN
               PERIOD: begin
                  if (per_hit || per_max) begin
                     state <= REPORT;
                     res_timeout <= ~per_hit;
                     start_s1 <= 1'b0;
                     res_valid <= 1'b1;
                  end
               end
`endif
               REPORT: begin
                  if (res_ready) begin
                     state <= IDLE;
                     res_valid <= 1'b0;
                     init_ready <= 1'b1;
                     done <= last_q;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// tb_gnr_attractor_ctrl: scoreboard bench with a behavioural node array (identity, 3-cycle, 4-bit counter).
module tb_gnr_attractor_ctrl;
   import gnr_pkg::*;
   localparam int N = GNR_N_NODES;
   localparam int W = GNR_CNT_W;
   localparam int MAXS = 16;
`ifdef GNR_CTRL_PERIOD_EN
   localparam bit PEN = 1'b1;
`else
   localparam bit PEN = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1, abort = 1'b0, init_valid = 1'b0, init_last = 1'b0, res_ready = 1'b0;
   logic [N-1:0] init_data = '0, s0_vec, s1_vec, init_state, res_init;
   logic init_ready, reset_nos, start_s0, start_s1, res_valid, res_timeout, done, ph;
   logic [W-1:0] res_steps, res_period;
   int mode = 0, n_checks = 0, n_fail = 0, done_cnt = 0;
   gnr_res_t sb[$];

   gnr_attractor_ctrl #(.N_NODES(N), .CNT_W(W), .MAX_STEPS(MAXS)) dut (
      .clk(clk), .rst(rst), .abort(abort), .init_valid(init_valid), .init_ready(init_ready),
      .init_data(init_data), .init_last(init_last), .s0_vec(s0_vec), .s1_vec(s1_vec),
      .reset_nos(reset_nos), .start_s0(start_s0), .start_s1(start_s1), .init_state(init_state),
      .res_valid(res_valid), .res_ready(res_ready), .res_init(res_init), .res_steps(res_steps),
      .res_period(res_period), .res_timeout(res_timeout), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] nf(input logic [N-1:0] x, input int m);
      logic [N-1:0] inc;
      inc = x + 1'b1;
      return m == 0 ? x : m == 1 ? (x >= 2 ? '0 : inc) : inc;
   endfunction

   // node array: hare advances on every start, tortoise on every second start
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_vec <= '0;
         s1_vec <= '0;
         ph <= 1'b0;
      end else if (reset_nos) begin
         s0_vec <= init_state;
         s1_vec <= init_state;
         ph <= 1'b0;
      end else begin
         if (start_s1) s1_vec <= nf(s1_vec, mode);
         if (start_s0) begin
            ph <= ~ph;
            if (ph) s0_vec <= nf(s0_vec, mode);
         end
      end
   end

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (!rst) begin
         n_checks++;
         if (reset_nos && (start_s0 || start_s1)) begin
            n_fail++;
            $display("FAIL start_with_reset_nos: got start_s0=%b start_s1=%b with reset_nos=1, want both 0", start_s0, start_s1);
         end
      end
   end

   function automatic gnr_res_t mk(input logic [N-1:0] i, input int s, input int p, input bit t);
      gnr_res_t r;
      r.init = i;
      r.steps = W'(s);
      r.period = PEN ? W'(p) : '0;
      r.timeout = t;
      return r;
   endfunction

   function automatic gnr_res_t obs();
      gnr_res_t r;
      r.init = res_init;
      r.steps = res_steps;
      r.period = res_period;
      r.timeout = res_timeout;
      return r;
   endfunction

   function automatic string fmt(input gnr_res_t r);
      return $sformatf("init=%h steps=%0d period=%0d timeout=%b", r.init, r.steps, r.period, r.timeout);
   endfunction

   task automatic send_init(input logic [N-1:0] d, input bit l, input int m, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = init_ready;
      end
      if (ok) begin
         mode = m;
         init_data = d;
         init_last = l;
         init_valid = 1'b1;
         @(posedge clk);
         #1 init_valid = 1'b0;
         init_last = 1'b0;
      end
   endtask

   task automatic wait_res(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = res_valid;
      end
   endtask

   task automatic wait_run(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = start_s1;
      end
   endtask

   task automatic take_res(output gnr_res_t r);
      r = obs();
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({init_ready, reset_nos, start_s0, start_s1, res_valid, done, res_timeout} !== 7'b0 ||
          res_init !== '0 || res_steps !== '0 || res_period !== '0 || init_state !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ready=%b rn=%b s0=%b s1=%b rv=%b done=%b %s, want all 0",
                  init_ready, reset_nos, start_s0, start_s1, res_valid, done, fmt(obs()));
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (init_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_before_clock: got %b, want 0", init_ready);
      end
      @(negedge clk);
      n_checks++;
      if (init_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_first_clock: got %b, want 1", init_ready);
      end
   endtask

   task automatic test_identity();
      bit ok;
      gnr_res_t r, e;
      sb.push_back(mk(4'b1010, 2, 1, 1'b0));
      send_init(4'b1010, 1'b0, 0, ok);
      wait_res(ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL identity_wait: got no res_valid, want %s", fmt(e));
      end else begin
         take_res(r);
         n_checks++;
         if (r !== e) begin
            n_fail++;
            $display("FAIL identity: got %s, want %s", fmt(r), fmt(e));
         end
      end
   endtask

   task automatic test_cycle3_hold();
      bit ok;
      gnr_res_t r, e;
      sb.push_back(mk(4'h0, 6, 3, 1'b0));
      send_init(4'h0, 1'b0, 1, ok);
      wait_res(ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL cycle3_wait: got no res_valid, want %s", fmt(e));
      end else begin
         for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (obs() !== e || {res_valid, init_ready, reset_nos, start_s0, start_s1} !== 5'b10000) begin
               n_fail++;
               $display("FAIL report_hold[%0d]: got %s rv=%b ready=%b rn=%b s0=%b s1=%b, want %s rv=1 others 0",
                        i, fmt(obs()), res_valid, init_ready, reset_nos, start_s0, start_s1, fmt(e));
            end
         end
         take_res(r);
         n_checks++;
         if (r !== e) begin
            n_fail++;
            $display("FAIL cycle3: got %s, want %s", fmt(r), fmt(e));
         end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      gnr_res_t r, e;
      sb.push_back(mk(4'h3, 0, 0, 1'b1));
      send_init(4'h3, 1'b0, 2, ok);
      wait_res(ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL timeout_wait: got no res_valid, want %s", fmt(e));
      end else begin
         take_res(r);
         n_checks++;
         if (r !== e) begin
            n_fail++;
            $display("FAIL timeout: got %s, want %s", fmt(r), fmt(e));
         end
      end
   endtask

   task automatic test_abort();
      bit ok;
      int rv_cnt;
      gnr_res_t r, e;
      send_init(4'h5, 1'b0, 2, ok);
      wait_run(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL abort_run_start: got start_s1=0, want 1");
      end
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({start_s0, start_s1, init_ready, res_valid, reset_nos} !== 5'b00100) begin
         n_fail++;
         $display("FAIL abort_idle: got s0=%b s1=%b ready=%b rv=%b rn=%b, want 0 0 1 0 0",
                  start_s0, start_s1, init_ready, res_valid, reset_nos);
      end
      rv_cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (res_valid) rv_cnt++;
      end
      n_checks++;
      if (rv_cnt != 0) begin
         n_fail++;
         $display("FAIL abort_no_result: got %0d res_valid cycles, want 0", rv_cnt);
      end
      sb.push_back(mk(4'h6, 2, 1, 1'b0));
      send_init(4'h6, 1'b0, 0, ok);
      wait_res(ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL after_abort_wait: got no res_valid, want %s", fmt(e));
      end else begin
         take_res(r);
         n_checks++;
         if (r !== e) begin
            n_fail++;
            $display("FAIL after_abort: got %s, want %s", fmt(r), fmt(e));
         end
      end
   endtask

   task automatic test_rst_in_run();
      bit ok;
      send_init(4'h9, 1'b0, 2, ok);
      wait_run(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL rst_run_start: got start_s1=0, want 1");
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({start_s0, start_s1, reset_nos, init_ready, res_valid} !== 5'b0 || res_init !== '0 || init_state !== '0) begin
         n_fail++;
         $display("FAIL rst_in_run: got s0=%b s1=%b rn=%b ready=%b rv=%b init=%h, want all 0",
                  start_s0, start_s1, reset_nos, init_ready, res_valid, res_init);
      end
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (start_s0 !== 1'b0 || start_s1 !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_residual_start: got s0=%b s1=%b, want 0 0", start_s0, start_s1);
      end
      rst = 1'b0;
   endtask

   task automatic test_batch_done();
      bit ok;
      gnr_res_t r, e;
      done_cnt = 0;
      for (int b = 0; b < 3; b++) begin
         sb.push_back(mk(N'(b + 1), 2, 1, 1'b0));
         send_init(N'(b + 1), b == 2, 0, ok);
         wait_res(ok);
         e = sb.pop_front();
         n_checks++;
         if (!ok) begin
            n_fail++;
            $display("FAIL batch_wait[%0d]: got no res_valid, want %s", b, fmt(e));
         end else begin
            take_res(r);
            n_checks++;
            if (r !== e) begin
               n_fail++;
               $display("FAIL batch[%0d]: got %s, want %s", b, fmt(r), fmt(e));
            end
            @(negedge clk);
            n_checks++;
            if (done !== (b == 2)) begin
               n_fail++;
               $display("FAIL batch_done[%0d]: got %b, want %b", b, done, b == 2);
            end
         end
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (done_cnt != 1) begin
         n_fail++;
         $display("FAIL done_pulses: got %0d, want 1", done_cnt);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test by 100000ns, want $finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_identity();
      test_cycle3_hold();
      test_timeout();
      test_abort();
      test_rst_in_run();
      test_batch_done();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
